pooling_engine: RTL and testbench
=================================

Name: pooling_engine

Overview:
- Parametrised, multi-channel streaming pooling unit; successor to the single-lane max/avg pooling top.
- Takes raster-ordered pixels (CHANNELS lanes per beat) from the systolic array output.
- Performs non-overlapping WIN x WIN max or average pooling (stride = WIN) using an internal partial-result line buffer.
- Emits pooled pixels over a valid/ready stream to the next layer's buffer.

Parameters:
- DATA_WIDTH, 8, signed two's-complement width of each lane.
- CHANNELS, 4, lanes processed in parallel per beat.
- MAX_COLS, 32, maximum feature-map width supported; line buffer holds MAX_COLS/WIN entries.
- MAX_ROWS, 32, maximum feature-map height.
- WIN, 2, pooling window and stride; power of two, 2..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse in IDLE; latches cfg_* and begins a map
- cfg_mode  in  1  0 = max, 1 = average
- cfg_cols  in  clog2(MAX_COLS)+1  map width; nonzero multiple of WIN
- cfg_rows  in  clog2(MAX_ROWS)+1  map height; nonzero multiple of WIN
- in_valid  in  1  input pixel valid
- in_data  in  CHANNELS*DATA_WIDTH  input pixel; lane c is bits [c*DW +: DW]
- in_ready  out  1  engine accepts the pixel this cycle
- out_valid  out  1  pooled pixel valid
- out_data  out  CHANNELS*DATA_WIDTH  pooled pixel
- out_ready  in  1  downstream accepts
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last pooled pixel is accepted

Behaviour:
- Reset values: in_ready = 0, out_valid = 0, out_data = 0, busy = 0, done = 0. State is IDLE; counters cleared. Line buffer contents are don't-care.
- Reset is asynchronous and may assert mid-map: the map is abandoned, with no done and no further output.
- FSM:
  - IDLE: start -> RUN, latching the config and clearing col/row counters.
  - RUN: in_ready = !out_valid || out_ready. After the final input beat, go to FLUSH.
  - FLUSH: wait until the final output is accepted, then pulse done and go to IDLE.
  - start outside IDLE is ignored.
- Transfers: an input beat transfers when in_valid && in_ready; an output beat transfers when out_valid && out_ready.
- Accumulation widths:
  - Max mode: DATA_WIDTH.
  - Average mode: ACC_W = DATA_WIDTH + 2*log2(WIN), signed with sign extension.
- Datapath, per accepted beat at (row r, col c), with wc = c mod WIN and wr = r mod WIN:
  - Horizontal register h: loaded with the pixel when wc = 0, otherwise combined with it (max or add).
  - At wc = WIN-1, entry c/WIN of the line buffer is written with h' (the updated h value) if wr = 0, otherwise with buf combine h'.
  - At wc = WIN-1 and wr = WIN-1 the result is final and goes to the output register instead.
- Average result: arithmetic right shift of the sum by 2*log2(WIN), i.e. floor (-3/4 -> -1). Lanes are independent.
- Latency: out_valid rises the cycle after the last contributing input beat transfers.
- Output register holds its data stable while out_valid && !out_ready. Backpressure stalls the input; no data is lost.
- Wrap-around: col wraps to 0 at cfg_cols-1 and increments row. The beat with row = cfg_rows-1 and col = cfg_cols-1 is the last input; in_ready is 0 after it until the next start.
- Outputs per map: (cfg_rows/WIN) * (cfg_cols/WIN), in raster order of windows.
- A simultaneous output accept and new input in the same cycle is legal and gives full throughput.
- Out-of-range cfg values (zero, or not a multiple of WIN) are not checked; behaviour is undefined.

Optional Feature:
- POOLING_RELU_EN.
- Defined: every output lane is clamped to max(result, 0) at the output register, after averaging. This adds no latency.
- Undefined: signed results pass through unchanged.

Decomposition:
- Package pooling_pkg holds:
  - pool_mode_e {POOL_MAX, POOL_AVG}
  - pool_state_e {IDLE, RUN, FLUSH}
  - localparam functions for ACC_W and the shift amount
- Sub-module pool_lane_combine: combinational per-lane max/add of two ACC_W operands selected by mode. Instantiated CHANNELS times for the horizontal combine and CHANNELS times for the vertical combine.

Test Plan:
- Max, WIN=2, 4x4 map, lane0 = raster index 0..15, no backpressure -> outputs 5, 7, 13, 15; done pulses once; first out_valid one cycle after beat 5.
- Avg, lane0 window {-1, -2, 0, 0} -> -3>>2 = -1; window {3, 3, 3, 2} -> 2; lanes 1..3 tracked independently with distinct values.
- out_ready held low for 5 cycles while an output is pending -> in_ready = 0, out_data stable; on release, all 4 outputs arrive in order with none lost or duplicated.
- rst asserted after 6 input beats, then a new start with an 8x2 map -> no stale outputs; 4 correct outputs follow.
- start pulsed during RUN -> ignored, counts unchanged; random full-throughput stream checked against a reference model, including lanes at -128 and 127.
- With POOLING_RELU_EN, max window {-5, -6, -7, -8} -> 0; without it -> -5.

Source files
------------

// File: rtl/pooling_engine_pkg.sv
// Shared types and width helpers for the streaming pooling engine.
package pooling_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pool_state_e;

    // Average divides by WIN*WIN, i.e. a right shift of 2*log2(WIN).
    function automatic int pool_shift(input int win);
        return 2 * $clog2(win);
    endfunction

    function automatic int pool_acc_w(input int dw, input int win);
        return dw + pool_shift(win);
    endfunction

endpackage

// File: rtl/pooling_engine_if.sv
// Control, configuration and pixel stream bundle of the pooling engine.
interface pooling_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int MAX_COLS   = 32,
    parameter int MAX_ROWS   = 32
);
    logic                           start;
    logic                           cfg_mode;
    logic [$clog2(MAX_COLS):0]      cfg_cols;
    logic [$clog2(MAX_ROWS):0]      cfg_rows;
    logic                           in_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           in_ready;
    logic                           out_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data;
    logic                           out_ready;
    logic                           busy;
    logic                           done;

    modport master (
        output start, cfg_mode, cfg_cols, cfg_rows, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, cfg_mode, cfg_cols, cfg_rows, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/pooling_engine_lane_combine.sv
// Single-lane combine: signed max or signed add of two accumulator-width operands.
module pool_lane_combine
    import pooling_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  pool_mode_e               mode,
    input  logic signed [ACC_W-1:0]  a,
    input  logic signed [ACC_W-1:0]  b,
    output logic signed [ACC_W-1:0]  y
);

    always_comb begin
        if (mode == POOL_AVG) y = a + b;
        else                  y = (a > b) ? a : b;
    end

endmodule

// File: rtl/pooling_engine.sv
// Streaming WIN x WIN max/average pooling over CHANNELS lanes with a partial-row line buffer.
// Optional POOLING_RELU_EN clamps every pooled lane at zero.
module pooling_engine
    import pooling_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int MAX_COLS   = 32,
    parameter int MAX_ROWS   = 32,
    parameter int WIN        = 2
) (
    input  logic             clk,
    input  logic             rst,
    pooling_engine_if.slave  bus
);

    localparam int DW    = DATA_WIDTH;
    localparam int ACC_W = pool_acc_w(DATA_WIDTH, WIN);
    localparam int SHIFT = pool_shift(WIN);
    localparam int LW    = $clog2(WIN);
    localparam int CW    = $clog2(MAX_COLS);
    localparam int RW    = $clog2(MAX_ROWS);
    localparam int NBUF  = MAX_COLS / WIN;

    pool_state_e          state, nxt;
    pool_mode_e           mode_q;
    logic [CW:0]          cols_q;
    logic [RW:0]          rows_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic                 in_ready, in_fire, out_fire, done;
    logic                 last_col, last_row, win_end, win_last_row;
    logic [LW-1:0]        wc, wr;
    logic [CW-LW-1:0]     buf_idx;

    logic signed [ACC_W-1:0] h_p0   [CHANNELS];
    logic signed [ACC_W-1:0] lb     [NBUF][CHANNELS];
    logic signed [ACC_W-1:0] pix_ext[CHANNELS];
    logic signed [ACC_W-1:0] h_comb [CHANNELS];
    logic signed [ACC_W-1:0] h_next [CHANNELS];
    logic signed [ACC_W-1:0] lb_rd  [CHANNELS];
    logic signed [ACC_W-1:0] v_comb [CHANNELS];

    logic                       vld_p1;
    logic [CHANNELS*DW-1:0]     out_data_p1;

    function automatic logic signed [ACC_W-1:0] avg_shift(input logic signed [ACC_W-1:0] v,
                                                           input pool_mode_e m);
        return (m == POOL_AVG) ? (v >>> SHIFT) : v;
    endfunction

    function automatic logic signed [DW-1:0] relu_clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v;
`ifdef POOLING_RELU_EN
        if (s < 0) s = '0;
`endif
        return DW'(s);
    endfunction

    assign wc           = col_q[LW-1:0];
    assign wr           = row_q[LW-1:0];
    assign buf_idx      = col_q[CW-1:LW];
    assign last_col     = ({1'b0, col_q} == cols_q - (CW+1)'(1));
    assign last_row     = ({1'b0, row_q} == rows_q - (RW+1)'(1));
    assign win_end      = (wc == LW'(WIN - 1));
    assign win_last_row = (wr == LW'(WIN - 1));
    assign in_fire      = bus.in_valid && in_ready;
    assign out_fire     = vld_p1 && bus.out_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic signed [DW-1:0] pix;
        assign pix        = bus.in_data[c*DW +: DW];
        assign pix_ext[c] = ACC_W'(pix);
        assign h_next[c]  = (wc == '0) ? pix_ext[c] : h_comb[c];
        assign lb_rd[c]   = lb[buf_idx][c];

        pool_lane_combine #(.ACC_W(ACC_W)) u_h_comb (
            .mode (mode_q), .a (h_p0[c]), .b (pix_ext[c]), .y (h_comb[c])
        );
        pool_lane_combine #(.ACC_W(ACC_W)) u_v_comb (
            .mode (mode_q), .a (lb_rd[c]), .b (h_next[c]), .y (v_comb[c])
        );
    end

    // Control: state, latched configuration and raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= POOL_MAX;
            cols_q <= '0;
            rows_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) begin
                mode_q <= pool_mode_e'(bus.cfg_mode);
                cols_q <= bus.cfg_cols;
                rows_q <= bus.cfg_rows;
                col_q  <= '0;
                row_q  <= '0;
            end else if (in_fire) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (bus.start) nxt = RUN;
            RUN: begin
                in_ready = !vld_p1 || bus.out_ready;
                if (bus.in_valid && in_ready && last_col && last_row) nxt = FLUSH;
            end
            FLUSH: begin
                if (out_fire) begin
                    done = 1'b1;
                    nxt  = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Stage p0: horizontal accumulator and line buffer of partial windows.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < CHANNELS; c++) begin
                h_p0[c] <= h_next[c];
                if (win_end && !win_last_row)
                    lb[buf_idx][c] <= (wr == '0) ? h_next[c] : v_comb[c];
            end
        end
    end

    // Stage p1: pooled output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
        end else if (in_fire && win_end && win_last_row) begin
            vld_p1 <= 1'b1;
            for (int c = 0; c < CHANNELS; c++)
                out_data_p1[c*DW +: DW] <= relu_clamp(avg_shift(v_comb[c], mode_q));
        end else if (out_fire) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = out_data_p1;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;

endmodule

// File: tb/tb_pooling_engine.sv
// Directed bench for pooling_engine: max/avg maps, backpressure, mid-map reset, ignored start, ReLU.
module tb_pooling_engine;

    localparam int DW  = 8;
    localparam int CH  = 4;
    localparam int MC  = 32;
    localparam int MR  = 32;
    localparam int WIN = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pooling_engine_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_COLS(MC), .MAX_ROWS(MR)) bus ();

    pooling_engine #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_COLS(MC), .MAX_ROWS(MR), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] got[$];
    int          vld_rise[$];
    int          done_cnt = 0;
    logic        prev_vld = 1'b0;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        if (bus.done) done_cnt++;
        if (bus.out_valid && !prev_vld) vld_rise.push_back(cyc);
        prev_vld = bus.out_valid;
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] beats[$];
    logic [31:0] ex[$];
    int          tx_cyc[64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic do_start(input int mode, input int cols, input int rows);
        bus.cfg_mode = mode[0];
        bus.cfg_cols = cols[5:0];
        bus.cfg_rows = rows[5:0];
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic send(input int lo, input int hi);
        int w;
        for (int i = lo; i <= hi; i++) begin
            w = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = beats[i];
            @(negedge clk);
            while (!bus.in_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (!bus.in_ready) begin
                chk($sformatf("in_ready_timeout_beat%0d", i), 64'(bus.in_ready), 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            tx_cyc[i] = cyc;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_map(input string tag, input int b, input int d);
        int w;
        w = 0;
        while ((got.size() < b + ex.size() || bus.busy) && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(got.size() - b), 64'(ex.size()));
        chk({tag, "_done"}, 64'(done_cnt - d), 64'd1);
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        for (int i = 0; i < ex.size() && b + i < got.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), 64'(got[b+i]), 64'(ex[i]));
    endtask

    // Window-by-window reference for the random maps.
    task automatic model(input int mode, input int cols, input int rows);
        logic signed [7:0] v;
        int acc, iv, k;
        logic [31:0] word;
        ex.delete();
        for (int wy = 0; wy < rows / WIN; wy++) begin
            for (int wx = 0; wx < cols / WIN; wx++) begin
                word = '0;
                for (int l = 0; l < CH; l++) begin
                    acc = (mode == 1) ? 0 : -1000;
                    for (int dy = 0; dy < WIN; dy++) begin
                        for (int dx = 0; dx < WIN; dx++) begin
                            k  = (wy * WIN + dy) * cols + wx * WIN + dx;
                            v  = beats[k][l*8 +: 8];
                            iv = v;
                            if (mode == 1) acc = acc + iv;
                            else if (iv > acc) acc = iv;
                        end
                    end
                    if (mode == 1) acc = acc >>> 2;
                    word[l*8 +: 8] = acc[7:0];
                end
                ex.push_back(word);
            end
        end
    endtask

    task automatic idx_beats();
        beats.delete();
        for (int i = 0; i < 16; i++) beats.push_back(pk(i, -i, 7, -1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b, d, vr;
        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_cols = '0; bus.cfg_rows = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Max 4x4, raster index in lane0, no backpressure.
        idx_beats();
        b = got.size(); d = done_cnt; vr = vld_rise.size();
        do_start(0, 4, 4);
        send(0, 15);
        ex = '{pk(5, 0, 7, -1), pk(7, -2, 7, -1), pk(13, -8, 7, -1), pk(15, -10, 7, -1)};
        check_map("max4x4", b, d);
        if (vld_rise.size() > vr) chk("max4x4_first_vld_cycle", 64'(vld_rise[vr]), 64'(tx_cyc[5]));
        else chk("max4x4_first_vld_seen", 64'(vld_rise.size()), 64'(vr + 1));
        chk("max4x4_throughput", 64'(tx_cyc[15] - tx_cyc[0]), 64'd15);

        // Average 4 cols x 2 rows, floor rounding, independent lanes.
        beats = '{pk(-1, 10, 127, 1), pk(-2, 20, 127, 0), pk(3, -128, -7, 5), pk(3, -128, 0, 5),
                  pk(0, 30, 127, 0),  pk(0, 40, 127, 0),  pk(3, -128, 0, 5),  pk(2, -128, 0, 6)};
        b = got.size(); d = done_cnt;
        do_start(1, 4, 2);
        send(0, 7);
        ex = '{pk(-1, 25, 127, 0), pk(2, -128, -2, 5)};
        check_map("avg4x2", b, d);

        // Backpressure: output pending with out_ready low stalls input.
        idx_beats();
        bus.out_ready = 1'b0;
        b = got.size(); d = done_cnt;
        do_start(0, 4, 4);
        send(0, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready_c%0d", k),  64'(bus.in_ready),  64'd0);
            chk($sformatf("bp_out_data_c%0d", k),  64'(bus.out_data),  64'(pk(5, 0, 7, -1)));
        end
        chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(6, 15);
        ex = '{pk(5, 0, 7, -1), pk(7, -2, 7, -1), pk(13, -8, 7, -1), pk(15, -10, 7, -1)};
        check_map("bp", b, d);

        // Asynchronous reset mid-map, then a fresh 8x2 map with a stray start.
        idx_beats();
        bus.out_ready = 1'b0;
        do_start(0, 4, 4);
        send(0, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_data",  64'(bus.out_data),  64'd0);
        chk("midrst_busy",      64'(bus.busy),      64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        b = got.size(); d = done_cnt;
        do_start(0, 8, 2);
        send(0, 7);
        bus.cfg_mode = 1'b1; bus.cfg_cols = 6'd2; bus.cfg_rows = 6'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("stray_start_busy", 64'(bus.busy), 64'd1);
        send(8, 15);
        ex = '{pk(9, 0, 7, -1), pk(11, -2, 7, -1), pk(13, -4, 7, -1), pk(15, -6, 7, -1)};
        check_map("rst8x2", b, d);

        // Random full-throughput maps with extreme lanes in the first window.
        for (int m = 0; m < 2; m++) begin
            int cols, rows;
            cols = (m == 0) ? 4 : 8;
            rows = 4;
            beats.delete();
            for (int i = 0; i < cols * rows; i++) beats.push_back($urandom);
            beats[0] = pk(-128, 127, -128, 127);
            beats[1] = pk(-128, 127, -128, 127);
            beats[cols] = pk(-128, 127, -128, 127);
            beats[cols+1] = pk(-128, 127, 127, -128);
            model(m, cols, rows);
            b = got.size(); d = done_cnt;
            do_start(m, cols, rows);
            send(0, cols * rows - 1);
            check_map((m == 0) ? "rand_max" : "rand_avg", b, d);
            chk((m == 0) ? "rand_max_thru" : "rand_avg_thru",
                64'(tx_cyc[cols*rows-1] - tx_cyc[0]), 64'(cols * rows - 1));
        end

        // All-negative max window: clamped only when ReLU is built in.
        beats = '{pk(-5, 3, 0, -1), pk(-6, 1, 0, -2), pk(-7, 2, 0, -3), pk(-8, 0, 0, -4)};
        b = got.size(); d = done_cnt;
        do_start(0, 2, 2);
        send(0, 3);
`ifdef POOLING_RELU_EN
        ex = '{pk(0, 3, 0, 0)};
`else
        ex = '{pk(-5, 3, 0, -1)};
`endif
        check_map("relu", b, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
